uart_reg_bridge: RTL and testbench

Bus-side front end for the UART peripheral: it is the initiator that drives the UART register port (divider, data write-with-wait, data read) from the core's peripheral bus. It decouples software from UART serial timing with a TX FIFO drained under the UART's wait handshake and an RX FIFO filled by polling the UART receive buffer. It sits between the peripheral interconnect and the UART instance.

---
 rtl/uart_reg_bridge.sv | 184 ++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// Bus-to-UART register bridge: a TX FIFO drained under the UART wait handshake
// and an RX FIFO filled by polling the UART receive buffer.
module uart_reg_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_gnt,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic [3:0]  uart_div_we,
    output logic [31:0] uart_div_di,
    input  logic [31:0] uart_div_do,
    output logic        uart_dat_we,
    output logic [31:0] uart_dat_di,
    input  logic [31:0] uart_dat_do,
    output logic        uart_dat_re,
    input  logic        uart_dat_wait
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = RAW + 1;

    typedef enum logic {RX_IDLE, RX_GUARD} rx_state_e;

    rx_state_e rx_state_q, rx_state_d;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic           ovf_q, ovf_d;
    logic           rvalid_q;
    logic [31:0]    rdata_q, rdata_d;

    logic sel_div, sel_dat, sel_sts, sel_ctl;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr, rd, tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic flush, ovf_clr;
    logic [31:0] status;
    logic unused_addr;

    assign unused_addr = ^bus_addr[1:0];

    assign sel_div = bus_addr[3:2] == 2'd0;
    assign sel_dat = bus_addr[3:2] == 2'd1;
    assign sel_sts = bus_addr[3:2] == 2'd2;
    assign sel_ctl = bus_addr[3:2] == 2'd3;

    assign tx_full  = tx_cnt_q == TCW'(TX_DEPTH);
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == RCW'(RX_DEPTH);
    assign rx_empty = rx_cnt_q == '0;

    assign uart_dat_we = !tx_empty;
    assign uart_dat_di = {24'h0, tx_mem[tx_rp_q]};
    assign tx_pop      = uart_dat_we && !uart_dat_wait;

    // A full TX FIFO still admits a write when the UART drains a byte this cycle
    assign bus_gnt = bus_req && !(bus_we && sel_dat && tx_full && !tx_pop);
    assign wr      = bus_gnt && bus_we;
    assign rd      = bus_gnt && !bus_we;

    assign tx_push = wr && sel_dat;
    assign rx_pop  = rd && sel_dat && !rx_empty;
    assign flush   = wr && sel_ctl && bus_wdata[1];
    assign ovf_clr = wr && sel_ctl && bus_wdata[0];
    assign rx_push = uart_dat_re && (!rx_full || rx_pop);
    assign rx_drop = uart_dat_re && rx_full && !rx_pop;

    assign uart_div_we = (wr && sel_div) ? bus_be : 4'h0;
    assign uart_div_di = bus_wdata;

    assign bus_rvalid = rvalid_q;
    assign bus_rdata  = rdata_q;

    assign status = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'b0,
                     ovf_q, rx_empty, rx_full, tx_empty, tx_full};

    always_ff @(posedge clk) begin
        if (!resetn) rx_state_q <= RX_IDLE;
        else         rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (uart_dat_do[31:8] == '0) rx_state_d = RX_GUARD;
            RX_GUARD: rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        uart_dat_re = (rx_state_q == RX_IDLE) && (uart_dat_do[31:8] == '0);
    end

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + TAW'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + TAW'(1);
            if (rx_push) rx_wp_d = rx_wp_q + RAW'(1);
            if (rx_pop)  rx_rp_d = rx_rp_q + RAW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_d = tx_cnt_q + TCW'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - TCW'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + RCW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - RCW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (rx_drop) ovf_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        case (1'b1)
            sel_div: rdata_d = uart_div_do;
            sel_dat: rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rp_q]};
            sel_sts: rdata_d = status;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
            rvalid_q <= bus_gnt;
            rdata_q  <= rd ? rdata_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push && !flush) tx_mem[tx_wp_q] <= bus_wdata[7:0];
        if (rx_push && !flush) rx_mem[rx_wp_q] <= uart_dat_do[7:0];
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a small UART divider model
// and monitors for accepted TX bytes and RX consume pulses.
module tb_uart_reg_bridge;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        bus_req, bus_we;
    logic [3:0]  bus_addr, bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic [3:0]  uart_div_we;
    logic [31:0] uart_div_di, uart_div_do;
    logic        uart_dat_we, uart_dat_re, uart_dat_wait;
    logic [31:0] uart_dat_di, uart_dat_do;

    int n_chk = 0;
    int n_fail = 0;
    int re_cnt = 0;
    logic [7:0] txq [$];
    logic [31:0] div_q = 32'd218;

    always #5 clk = ~clk;

    uart_reg_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .resetn(resetn),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .uart_div_we(uart_div_we), .uart_div_di(uart_div_di),
        .uart_div_do(uart_div_do),
        .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
        .uart_dat_do(uart_dat_do), .uart_dat_re(uart_dat_re),
        .uart_dat_wait(uart_dat_wait)
    );

    assign uart_div_do = div_q;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (uart_div_we[b]) div_q[b*8 +: 8] <= uart_div_di[b*8 +: 8];
        if (uart_dat_we && !uart_dat_wait) txq.push_back(uart_dat_di[7:0]);
        if (uart_dat_re) re_cnt <= re_cnt + 1;
    end

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the response edge
    task automatic xfer(input logic we, input logic [3:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic [3:0] dwe);
        int n = 0;
        bus_req = 1'b1;
        bus_we = we;
        bus_addr = a;
        bus_be = be;
        bus_wdata = wd;
        #4;
        while (!bus_gnt && n < 50) begin
            @(posedge clk);
            #5;
            n++;
        end
        dwe = uart_div_we;
        if (!bus_gnt) chk("gnt_timeout", {31'h0, bus_gnt}, 32'h1);
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        rdat = bus_rdata;
        chk("rvalid", {31'h0, bus_rvalid}, 32'h1);
    endtask

    task automatic rd(input logic [3:0] a, input string name,
                      input logic [31:0] exp);
        logic [31:0] r;
        logic [3:0] d;
        xfer(1'b0, a, 4'h0, 32'h0, r, d);
        chk(name, r, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic [3:0] d;
        xfer(1'b1, a, 4'hF, wd, r, d);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0] d;
        logic ok;
        logic [7:0] expq [$];
        int n;

        vec[0] = '{1'b0, 4'h8, 4'h0, 32'h0, 32'h0000_000A};
        vec[1] = '{1'b0, 4'h0, 4'h0, 32'h0, 32'd218};
        vec[2] = '{1'b1, 4'h0, 4'h1, 32'h55, 32'h1};
        vec[3] = '{1'b0, 4'h0, 4'h0, 32'h0, 32'h0000_0055};
        vec[4] = '{1'b1, 4'h0, 4'h2, 32'h0000_1277, 32'h2};
        vec[5] = '{1'b0, 4'h0, 4'h0, 32'h0, 32'h0000_1255};
        vec[6] = '{1'b1, 4'h8, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vec[7] = '{1'b0, 4'h9, 4'h0, 32'h0, 32'h0000_000A};
        vec[8] = '{1'b0, 4'hC, 4'h0, 32'h0, 32'h0};
        vec[9] = '{1'b0, 4'h4, 4'h0, 32'h0, 32'hFFFF_FFFF};

        resetn = 1'b0;
        bus_req = 1'b1;
        bus_we = 1'b0;
        bus_addr = 4'h8;
        bus_be = 4'h0;
        bus_wdata = 32'h0;
        uart_dat_do = 32'hFFFF_FFFF;
        uart_dat_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs",
            {24'h0, bus_gnt, bus_rvalid, uart_div_we, uart_dat_we, uart_dat_re},
            32'h80);
        chk("reset_rdata", bus_rdata, 32'h0);
        bus_req = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            xfer(vec[i].we, vec[i].addr, vec[i].be, vec[i].wdata, r, d);
            if (vec[i].we) chk($sformatf("vec%0d_divwe", i), {28'h0, d}, vec[i].exp);
            else           chk($sformatf("vec%0d_rdata", i), r, vec[i].exp);
        end

        uart_dat_wait = 1'b1;
        wr(4'h4, 32'h41);
        chk("tx_offer_lat", {uart_dat_di[31:1], uart_dat_we}, 32'h41);
        wr(4'h4, 32'h142);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!(uart_dat_we && uart_dat_di == 32'h41)) ok = 1'b0;
        end
        chk("tx_hold_stable", {31'h0, ok}, 32'h1);
        rd(4'h8, "sts_tx2", 32'h0000_0208);
        uart_dat_wait = 1'b0;
        @(posedge clk);
        #1;
        chk("tx_next_offer", {uart_dat_di[31:1], uart_dat_we}, 32'h43);
        uart_dat_wait = 1'b1;
        rd(4'h8, "sts_tx1", 32'h0000_0108);
        uart_dat_wait = 1'b0;
        @(posedge clk);
        #1;
        chk("tx_drained", {31'h0, uart_dat_we}, 32'h0);

        uart_dat_wait = 1'b1;
        for (int i = 0; i < TXD; i++) wr(4'h4, 32'h10 + i);
        rd(4'h8, "sts_tx_full", 32'h0000_1009);
        bus_req = 1'b1;
        bus_we = 1'b1;
        bus_addr = 4'h4;
        bus_wdata = 32'h20;
        ok = 1'b1;
        #4;
        if (bus_gnt) ok = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #5;
            if (bus_gnt) ok = 1'b0;
        end
        chk("tx_full_stall", {31'h0, ok}, 32'h1);
        uart_dat_wait = 1'b0;
        #1;
        chk("tx_full_gnt_on_pop", {31'h0, bus_gnt}, 32'h1);
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        chk("tx_full_rvalid", {31'h0, bus_rvalid}, 32'h1);
        n = 0;
        while (uart_dat_we && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tx_drain_done", {31'h0, uart_dat_we}, 32'h0);
        expq = '{8'h41, 8'h42};
        for (int i = 0; i < TXD; i++) expq.push_back(8'(8'h10 + i));
        expq.push_back(8'h20);
        chk("tx_byte_count", txq.size(), expq.size());
        ok = 1'b1;
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            if (txq[i] !== expq[i]) ok = 1'b0;
        chk("tx_byte_order", {31'h0, ok}, 32'h1);

        uart_dat_do = 32'h0000_005A;
        #1;
        chk("rx_re_comb", {31'h0, uart_dat_re}, 32'h1);
        @(posedge clk);
        #1;
        uart_dat_do = 32'hFFFF_FFFF;
        chk("rx_guard", {31'h0, uart_dat_re}, 32'h0);
        rd(4'h4, "rx_read1", 32'h0000_005A);
        rd(4'h4, "rx_read_empty", 32'hFFFF_FFFF);
        chk("rx_one_pulse", re_cnt, 32'd1);

        for (int i = 0; i < RXD; i++) begin
            uart_dat_do = 32'h60 + i;
            @(posedge clk);
            #1;
            uart_dat_do = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
        end
        rd(4'h8, "sts_rx_full", 32'h0010_0006);
        uart_dat_do = 32'h33;
        @(posedge clk);
        #1;
        uart_dat_do = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("rx_consumed", re_cnt, 32'd18);
        rd(4'h8, "sts_ovf", 32'h0010_0016);
        wr(4'hC, 32'h1);
        rd(4'h8, "sts_ovf_clr", 32'h0010_0006);
        rd(4'h4, "rx_head", 32'h0000_0060);
        rd(4'h8, "sts_rx15", 32'h000F_0002);
        uart_dat_wait = 1'b1;
        wr(4'h4, 32'h77);
        rd(4'h8, "sts_pre_flush", 32'h000F_0100);
        wr(4'hC, 32'h2);
        chk("flush_we_drop", {31'h0, uart_dat_we}, 32'h0);
        rd(4'h8, "sts_flushed", 32'h0000_000A);

        wr(4'h4, 32'h99);
        bus_req = 1'b1;
        bus_we = 1'b0;
        bus_addr = 4'h8;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_mid",
            {29'h0, bus_rvalid, uart_dat_we, |bus_rdata}, 32'h0);
        bus_req = 1'b0;
        resetn = 1'b1;
        uart_dat_wait = 1'b0;
        rd(4'h8, "sts_after_reset", 32'h0000_000A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
